// File: rtl/flag_hazard_controller.sv
// flag_hazard_controller
//   Scheduler between the ID stage and the {z,c,n,v} status register for
//   conditional execution. Owns the status register, counts in-flight
//   flag-setting (S-bit) instructions, stalls a conditional instruction in ID
//   until its flags are final, then marks it execute or squash.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   issue_valid     ID holds a valid instruction
//   issue_cond      ARM condition field
//   issue_set_flags instruction writes flags (S bit)
//   freeze          global pipeline freeze; only flag writes change state
//   flush           branch-taken flush; kills all un-written flag-setters
//   flags_wr_en     EXE/WB writes a flag result this cycle
//   flags_in        {z,c,n,v} result being written
//   issue_stall     hold ID this cycle
//   issue_exec      accepted, condition true
//   issue_squash    accepted, condition false (ID becomes a bubble)
//   stat_reg        current {z,c,n,v}
//   pending_cnt     flag-setters in flight
//   timeout_err     sticky watchdog flag (stall held too long)
module flag_hazard_controller #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2,
  parameter int WAIT_MAX    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [3:0]       issue_cond,
  input  logic             issue_set_flags,
  input  logic             freeze,
  input  logic             flush,
  input  logic             flags_wr_en,
  input  logic [3:0]       flags_in,
  output logic             issue_stall,
  output logic             issue_exec,
  output logic             issue_squash,
  output logic [3:0]       stat_reg,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             timeout_err
);

  localparam int         WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  logic [3:0]       stat_q,    stat_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  state_t           state_q,   state_d;
  logic [WAIT_W-1:0] wait_q,   wait_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       eff;
  logic             z, c, n, v;
  logic             cond_true;
  logic [CNT_W-1:0] pend_excl;
  logic             stall;
  logic             accept;
  logic             inc;
  logic [CNT_W:0]   cnt_sum;

  // Condition evaluation. When the last in-flight setter writes this cycle,
  // its result is forwarded so the waiting instruction resolves without an
  // extra stall cycle.
  always_comb begin
    eff = (flags_wr_en && cnt_q == CNT_W'(1)) ? flags_in : stat_q;
    {z, c, n, v} = eff;
    cond_true = 1'b0;
    case (issue_cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = z | (n != v);
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Stall / accept. A write landing this cycle retires one setter, so it is
  // discounted before deciding whether a conditional must wait.
  always_comb begin
    pend_excl = (flags_wr_en && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    stall = rst & issue_valid & ~freeze & ~flush &
            (((issue_cond != COND_AL) && (pend_excl != '0)) ||
             (issue_set_flags && (cnt_q == CNT_W'(MAX_PENDING)) && !flags_wr_en));
    accept = rst & issue_valid & ~stall & ~freeze & ~flush;
    inc    = accept & cond_true & issue_set_flags;
  end

  // Next-state logic for counter, FSM, watchdog and status register.
  always_comb begin
    stat_d    = flags_wr_en ? flags_in : stat_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    cnt_sum   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};

    if (flush) begin
      cnt_d   = '0;
      state_d = RUN;
      wait_d  = '0;
    end else if (!freeze) begin
      // Decrement saturates at zero for writes with nothing in flight.
      if (flags_wr_en && cnt_sum != '0) begin
        cnt_sum = cnt_sum - {{CNT_W{1'b0}}, 1'b1};
      end
      cnt_d = cnt_sum[CNT_W-1:0];

      case (state_q)
        RUN: begin
          if (stall) begin
            state_d = HOLD;
          end
          wait_d = '0;
        end
        HOLD: begin
          if (accept) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q != WAIT_W'(WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
          end
          if (!accept && wait_d == WAIT_W'(WAIT_MAX)) begin
            timeout_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q    <= '0;
      cnt_q     <= '0;
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      stat_q    <= stat_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign issue_stall  = stall;
  assign issue_exec   = accept & cond_true;
  assign issue_squash = accept & ~cond_true;
  assign stat_reg     = stat_q;
  assign pending_cnt  = cnt_q;
  assign timeout_err  = timeout_q;

endmodule
